bubble_power_sequencer: RTL
===========================

Name: bubble_power_sequencer

Overview:
- Power-up sequencer that produces the READY handshake toward the BUBBLE SYSTEM board (temperature_low).
- Watches the board's power_good and latches the image selection once per power cycle.
- Requests an image load from SPILoader, then emulates the bubble-memory heater warm-up delay.
- Only then enables BubbleInterface and releases temperature_low.

Parameters:
DEBOUNCE_CYCLES, 48000, consecutive cycles power_good must stay high before sequencing starts (1 ms at 48 MHz); must be >= 1
WARMUP_CYCLES, 4800000, heater-emulation delay after image load completes (100 ms at 48 MHz); must be >= 1

Ports:
master_clock  in  1  48 MHz master clock; all logic on its rising edge
master_reset  in  1  synchronous, active-high reset
power_good  in  1  from BUBBLE SYSTEM board, asynchronous; 1 = supply good
image_dip_switch  in  3  on-board DIP, active-low image select
load_done  in  1  from SPILoader; 1 = image load complete (level or pulse)
flash_error  in  1  from SPILoader; 1 = flash read failed
load_request  out  1  to SPILoader; held 1 while a load is wanted
image_number  out  3  to SPILoader; image index latched once per power cycle
bubble_interface_enable  out  1  to BubbleInterface; 1 = interface enabled
temperature_low  out  1  to BUBBLE SYSTEM board; 1 = not ready (cold), 0 = ready
fault  out  1  1 = flash error latched this power cycle

Behaviour:
- Synchronizer: power_good passes through a 2-FF synchronizer to give pg_s. No other logic uses the raw input.
- FSM states: IDLE, DEBOUNCE, LATCH, LOAD, WARMUP, READY, FAULT.
- One shared counter, wide enough for max(DEBOUNCE_CYCLES, WARMUP_CYCLES) - 1. It clears on every state change.
- Reset values: state=IDLE, counter=0, load_request=0, image_number=3'b000, bubble_interface_enable=0, temperature_low=1, fault=0.
- IDLE: if pg_s=1, go to DEBOUNCE.
- DEBOUNCE: counter increments each cycle.
  - pg_s=0 -> IDLE.
  - counter == DEBOUNCE_CYCLES-1 with pg_s=1 -> LATCH.
- LATCH: exactly one cycle. image_number <= ~image_dip_switch, then -> LOAD. image_number is not updated anywhere else; DIP changes after LATCH are ignored until the next power cycle.
- LOAD: load_request=1.
  - flash_error=1 -> FAULT. flash_error wins if it arrives in the same cycle as load_done.
  - otherwise load_done=1 -> WARMUP.
  - No timeout.
- WARMUP: counter increments; counter == WARMUP_CYCLES-1 -> READY.
- READY: temperature_low=0, bubble_interface_enable=1. Held indefinitely.
- FAULT: fault=1, temperature_low=1, bubble_interface_enable=0. Held until power loss or reset.
- Power loss: pg_s=0 in any state other than IDLE -> IDLE on the next edge. This applies even mid-LOAD or mid-WARMUP.
  - Outputs return to reset values except image_number, which holds its value.
  - Power loss also clears fault.
- master_reset has priority over all transitions.
- Outputs are registered: each output updates on the same edge as the state change that sets it.
- Output decode by state:
  - load_request=1 only in LOAD.
  - bubble_interface_enable=1 only in READY.
  - temperature_low=0 only in READY.
- Latency from pg_s rising to READY = 1 + DEBOUNCE_CYCLES + 1 + (LOAD cycles) + WARMUP_CYCLES edges. Minimum LOAD cycles = 1.

Optional Feature:
BUBBLE_WARMUP_DELAY_EN
- Defined: WARMUP state and WARMUP_CYCLES behave as above.
- Undefined: WARMUP state and its counter use are removed; LOAD goes directly to READY on load_done (fast boot for bench/debug). WARMUP_CYCLES is ignored.

Test Plan:
- Nominal boot (DEBOUNCE_CYCLES=4, WARMUP_CYCLES=8, macro defined, dip=3'b101):
  - Stimulus: raise power_good; assert load_done 3 cycles after load_request rises.
  - Response: image_number=3'b010; load_request high for exactly 3 cycles; temperature_low falls and enable rises exactly 8 edges after load_done is sampled.
- Glitch rejection: power_good high for 3 cycles then low, repeated.
  - Response: never leaves IDLE/DEBOUNCE; load_request stays 0; image_number stays 0.
- Error path: flash_error=1 and load_done=1 in the same LOAD cycle.
  - Response: fault=1, load_request=0, temperature_low=1, enable=0, held 100 cycles.
  - Then drop power_good: fault=0 after sync + 1 edge.
- Power loss mid-WARMUP at counter=5.
  - Response: IDLE; temperature_low=1, enable=0; image_number retained.
  - Re-raise power_good with dip=3'b000: new image_number=3'b111; full sequence repeats.
- master_reset asserted in READY.
  - Response: on the next edge all outputs equal reset values, including image_number=0.
  - With power_good still high, the sequence restarts from DEBOUNCE.
- Macro undefined: load_done sampled -> READY on the next edge; temperature_low=0 one edge after load_done.

Source files
------------

// File: rtl/bubble_power_sequencer_if.sv
// Board / SPILoader / BubbleInterface signal bundle for the power sequencer.
// master = sequencer side, slave = board and loader side.
interface bubble_power_sequencer_if;
    logic       power_good;
    logic [2:0] image_dip_switch;
    logic       load_done;
    logic       flash_error;
    logic       load_request;
    logic [2:0] image_number;
    logic       bubble_interface_enable;
    logic       temperature_low;
    logic       fault;

    modport master (
        input  power_good,
        input  image_dip_switch,
        input  load_done,
        input  flash_error,
        output load_request,
        output image_number,
        output bubble_interface_enable,
        output temperature_low,
        output fault
    );

    modport slave (
        output power_good,
        output image_dip_switch,
        output load_done,
        output flash_error,
        input  load_request,
        input  image_number,
        input  bubble_interface_enable,
        input  temperature_low,
        input  fault
    );
endinterface

// File: rtl/bubble_power_sequencer.sv
// Power-up sequencer: debounce power_good, latch image, load, warm up, ready.
// Macro BUBBLE_WARMUP_DELAY_EN enables the heater warm-up delay state.
module bubble_power_sequencer #(
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter int WARMUP_CYCLES   = 4800000
) (
    input  logic                     master_clock,
    input  logic                     master_reset,
    bubble_power_sequencer_if.master bus
);
    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > WARMUP_CYCLES) ?
                                DEBOUNCE_CYCLES : WARMUP_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef BUBBLE_WARMUP_DELAY_EN
    localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE, DEBOUNCE, LATCH, LOAD, WARMUP, READY, FAULT
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          pg_meta;
    logic          pg_s;
    logic          load_request;
    logic [2:0]    image_number;
    logic          interface_enable;
    logic          temperature_low;
    logic          fault;

    assign bus.load_request            = load_request;
    assign bus.image_number            = image_number;
    assign bus.bubble_interface_enable = interface_enable;
    assign bus.temperature_low         = temperature_low;
    assign bus.fault                   = fault;

    // Two-flop synchronizer for the asynchronous power_good input
    always_ff @(posedge master_clock) begin
        if (master_reset) begin
            pg_meta <= 1'b0;
            pg_s    <= 1'b0;
        end else begin
            pg_meta <= bus.power_good;
            pg_s    <= pg_meta;
        end
    end

    // Sequencer FSM; power loss drops to IDLE but keeps the latched image
    always_ff @(posedge master_clock) begin
        if (master_reset) begin
            state            <= IDLE;
            count            <= '0;
            load_request     <= 1'b0;
            image_number     <= 3'b000;
            interface_enable <= 1'b0;
            temperature_low  <= 1'b1;
            fault            <= 1'b0;
        end else if (!pg_s && state != IDLE) begin
            state            <= IDLE;
            count            <= '0;
            load_request     <= 1'b0;
            interface_enable <= 1'b0;
            temperature_low  <= 1'b1;
            fault            <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pg_s) begin
                        state <= DEBOUNCE;
                        count <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (count == DEB_LAST) begin
                        state <= LATCH;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                LATCH: begin
                    image_number <= ~bus.image_dip_switch;
                    load_request <= 1'b1;
                    state        <= LOAD;
                end
                LOAD: begin
                    if (bus.flash_error) begin
                        state        <= FAULT;
                        load_request <= 1'b0;
                        fault        <= 1'b1;
                    end else if (bus.load_done) begin
                        load_request <= 1'b0;
                        count        <= '0;
`ifdef BUBBLE_WARMUP_DELAY_EN
                        state        <= WARMUP;
`else
                        state            <= READY;
                        interface_enable <= 1'b1;
                        temperature_low  <= 1'b0;
`endif
                    end
                end
`ifdef BUBBLE_WARMUP_DELAY_EN
                WARMUP: begin
                    if (count == WARM_LAST) begin
                        state            <= READY;
                        count            <= '0;
                        interface_enable <= 1'b1;
                        temperature_low  <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
`endif
                READY: begin
                    state <= READY;
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end
endmodule
